// File: rtl/hcmd_issuer.sv
// Host-side IFQueue command issuer: serialises one CDB as 32-bit rows on the
// command queue, then polls its status on the query port until complete, error or timeout.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE and a request offered while busy is dropped, not queued.
module hcmd_issuer #(
    parameter int CDB_ROWS    = 8,
    parameter int POLL_GAP    = 4,
    parameter int RSP_TIMEOUT = 16,
    parameter int MAX_POLLS   = 255
) (
    input  logic                    clock_host,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [CDB_ROWS*32-1:0]  req_cdb,
    input  logic [7:0]              req_tag,
    output logic                    req_ready,
    output logic                    cmdq_select,
    output logic [31:0]             cmdq_data,
    output logic                    queryin_select,
    output logic [7:0]              querydata_out,
    output logic                    querydata_oe,
    input  logic                    queryout_select,
    input  logic [7:0]              querydata_in,
    output logic                    done,
    output logic [1:0]              done_status,
    output logic                    timeout_err,
    output logic                    busy,
    output logic [2:0]              dbg_state
);
    localparam int ROW_W  = (CDB_ROWS > 1) ? $clog2(CDB_ROWS) : 1;
    localparam int WAIT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(CDB_ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RSP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [7:0]        POLL_MAX  = 8'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_QUERY, S_WAIT_RSP, S_GAP, S_DONE, S_TERR
    } state_t;

    state_t                  state;
    logic [CDB_ROWS*32-1:0]  cdb_q;
    logic [7:0]              tag_q;
    logic [ROW_W-1:0]        row_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [7:0]              poll_cnt;

    logic       rsp_hit;
    logic       rsp_final;
    logic       poll_fail;
    logic [7:0] poll_next;
    logic       unused_query_bits;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Status bit 3 set means complete (11) or error (10); anything else is still pending.
    assign rsp_hit   = queryout_select && (state == S_QUERY || state == S_WAIT_RSP);
    assign rsp_final = rsp_hit && querydata_in[3];
    assign poll_fail = (rsp_hit && !querydata_in[3]) ||
                       (state == S_WAIT_RSP && !queryout_select && wait_cnt == WAIT_LAST);
    assign poll_next = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
    assign unused_query_bits = ^{querydata_in[7:4], querydata_in[1:0]};

    always_ff @(posedge clock_host or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cdb_q          <= '0;
            tag_q          <= '0;
            row_cnt        <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            poll_cnt       <= '0;
            cmdq_select    <= 1'b0;
            cmdq_data      <= '0;
            queryin_select <= 1'b0;
            querydata_out  <= '0;
            querydata_oe   <= 1'b0;
            done           <= 1'b0;
            done_status    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        // Row 0 goes out straight from the request; the rest shift out of cdb_q.
                        cmdq_select <= 1'b1;
                        cmdq_data   <= req_cdb[31:0];
                        cdb_q       <= req_cdb >> 32;
                        tag_q       <= req_tag;
                        row_cnt     <= '0;
                        poll_cnt    <= '0;
                        done_status <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (row_cnt == ROW_LAST) begin
                        cmdq_select    <= 1'b0;
                        cmdq_data      <= '0;
                        queryin_select <= 1'b1;
                        querydata_oe   <= 1'b1;
                        querydata_out  <= tag_q;
                        wait_cnt       <= '0;
                        state          <= S_QUERY;
                    end else begin
                        cmdq_data <= cdb_q[31:0];
                        cdb_q     <= cdb_q >> 32;
                        row_cnt   <= row_cnt + 1'b1;
                    end
                end
                S_QUERY, S_WAIT_RSP: begin
                    queryin_select <= 1'b0;
                    querydata_oe   <= 1'b0;
                    querydata_out  <= '0;
                    if (rsp_final) begin
                        done_status <= querydata_in[3:2];
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (poll_fail) begin
                        poll_cnt <= poll_next;
                        if (poll_next == POLL_MAX) begin
                            timeout_err <= 1'b1;
                            done_status <= 2'b00;
                            state       <= S_TERR;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else begin
                        if (state == S_WAIT_RSP) wait_cnt <= wait_cnt + 1'b1;
                        state <= S_WAIT_RSP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        queryin_select <= 1'b1;
                        querydata_oe   <= 1'b1;
                        querydata_out  <= tag_q;
                        wait_cnt       <= '0;
                        state          <= S_QUERY;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                S_TERR: begin
                    timeout_err <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hcmd_issuer.sv
// Bench for hcmd_issuer: directed table, randomized polls against an event-level
// model of poll timing, and hand-written reset/idle sequences.
module tb_hcmd_issuer;
  localparam int ROWS = 8;
  localparam int GAP  = 4;
  localparam int TMO  = 4;
  localparam int MAXP = 3;

  // ---------------- clock / reset ----------------
  logic         clock_host = 1'b0;
  logic         reset      = 1'b1;
  logic         req_valid  = 1'b0;
  logic [255:0] req_cdb    = '0;
  logic [7:0]   req_tag    = '0;
  logic         req_ready, cmdq_select, queryin_select, querydata_oe;
  logic [31:0]  cmdq_data;
  logic [7:0]   querydata_out;
  logic         queryout_select = 1'b0;
  logic [7:0]   querydata_in    = '0;
  logic         done, timeout_err, busy;
  logic [1:0]   done_status;
  logic [2:0]   dbg_state;

  always #5 clock_host = ~clock_host;

  hcmd_issuer #(.CDB_ROWS(ROWS), .POLL_GAP(GAP), .RSP_TIMEOUT(TMO), .MAX_POLLS(MAXP)) dut (
    .clock_host(clock_host), .reset(reset),
    .req_valid(req_valid), .req_cdb(req_cdb), .req_tag(req_tag), .req_ready(req_ready),
    .cmdq_select(cmdq_select), .cmdq_data(cmdq_data),
    .queryin_select(queryin_select), .querydata_out(querydata_out), .querydata_oe(querydata_oe),
    .queryout_select(queryout_select), .querydata_in(querydata_in),
    .done(done), .done_status(done_status), .timeout_err(timeout_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clock_host) cyc <= cyc + 1;

  logic [31:0] row_q[$];
  int          row_cyc_q[$];
  int          qry_cyc_q[$];
  logic [7:0]  qry_tag_q[$];
  int          done_cnt = 0;
  int          terr_cnt = 0;
  int          oe_bad   = 0;
  int          stray    = 0;

  always @(negedge clock_host) begin
    if (cmdq_select) begin
      row_q.push_back(cmdq_data);
      row_cyc_q.push_back(cyc);
    end else if (cmdq_data != 32'h0) stray++;
    if (queryin_select) begin
      qry_cyc_q.push_back(cyc);
      qry_tag_q.push_back(querydata_out);
      if (!querydata_oe) oe_bad++;
    end else if (querydata_oe || querydata_out != 8'h0) oe_bad++;
    if (done) done_cnt++;
    if (timeout_err) terr_cnt++;
  end

  // ---------------- responder driver ----------------
  // plan_d[i]: cycles after query i that the one-cycle response comes (-1: never)
  int         plan_d[MAXP];
  logic [7:0] plan_v[MAXP];
  bit         force_rsp = 1'b0;
  logic [7:0] force_val = '0;
  int         poll_idx = 0;
  int         resp_at = -1;
  logic [7:0] resp_val = '0;

  always @(negedge clock_host) begin
    queryout_select = 1'b0;
    querydata_in    = 8'h00;
    if (!busy) poll_idx = 0;
    if (queryin_select) begin
      if (poll_idx < MAXP && plan_d[poll_idx] >= 0) begin
        resp_at  = cyc + plan_d[poll_idx];
        resp_val = plan_v[poll_idx];
      end
      poll_idx++;
    end
    if (force_rsp) begin
      queryout_select = 1'b1;
      querydata_in    = force_val;
    end else if (resp_at == cyc) begin
      queryout_select = 1'b1;
      querydata_in    = resp_val;
    end
  end

  // ---------------- reference model ----------------
  // Query offsets relative to the first query; first query is 9 cycles after accept.
  logic [31:0] exp_q[$];

  task automatic model(output int kind, output int at, output logic [1:0] st);
    int q = 0;
    int f;
    exp_q.delete();
    kind = 0; at = 0; st = 2'b00;
    for (int i = 0; i < MAXP; i++) begin
      exp_q.push_back(q);
      if (plan_d[i] >= 0 && plan_v[i][3]) begin
        kind = 1; at = q + plan_d[i] + 1; st = plan_v[i][3:2];
        return;
      end
      f = (plan_d[i] >= 0) ? q + plan_d[i] : q + TMO;
      if (i + 1 == MAXP) begin
        kind = 2; at = f + 1; st = 2'b00;
        return;
      end
      q = f + 1 + GAP;
    end
  endtask

  // ---------------- transaction driver + scoreboard ----------------
  task automatic run_txn(input logic [255:0] cdb, input logic [7:0] tag, input bit poke,
                         output int obs_kind, output logic [1:0] obs_st, output int obs_np);
    int c0, ek, ea, rb, qb, db, tb, hit_cyc;
    logic [1:0] es;
    model(ek, ea, es);
    @(negedge clock_host);
    chk("ready_idle", req_ready, 1);
    rb = row_q.size(); qb = qry_cyc_q.size(); db = done_cnt; tb = terr_cnt;
    req_valid = 1'b1; req_cdb = cdb; req_tag = tag; c0 = cyc;
    @(negedge clock_host);
    req_valid = 1'b0; req_cdb = ~cdb; req_tag = ~tag;
    chk("busy_after_accept", {req_ready, busy}, 2'b01);
    chk("status_cleared", done_status, 0);
    if (poke) begin
      @(negedge clock_host); req_valid = 1'b1;
      @(negedge clock_host); req_valid = 1'b0;
    end
    hit_cyc = -1; obs_kind = 0; obs_st = 2'b00;
    for (int b = 0; b < 300; b++) begin
      @(negedge clock_host);
      if (done || timeout_err) begin
        hit_cyc = cyc; obs_st = done_status; obs_kind = done ? 1 : 2;
        break;
      end
    end
    chk("pulse_seen", hit_cyc >= 0, 1);
    chk("outcome_kind", obs_kind, ek);
    chk("outcome_cycle", hit_cyc, c0 + 9 + ea);
    chk("outcome_status", obs_st, es);
    @(negedge clock_host);
    chk("idle_after", {req_ready, busy, done, timeout_err}, 4'b1000);
    chk("status_held", done_status, es);
    repeat (3) @(negedge clock_host);
    chk("done_pulses", done_cnt - db, ek == 1);
    chk("terr_pulses", terr_cnt - tb, ek == 2);
    chk("row_count", row_q.size() - rb, ROWS);
    for (int k = 0; k < ROWS && rb + k < row_q.size(); k++) begin
      chk($sformatf("row%0d_data", k), row_q[rb+k], cdb[32*k +: 32]);
      chk($sformatf("row%0d_cycle", k), row_cyc_q[rb+k], c0 + 1 + k);
    end
    obs_np = qry_cyc_q.size() - qb;
    chk("poll_count", obs_np, exp_q.size());
    for (int i = 0; i < obs_np && i < exp_q.size(); i++) begin
      chk($sformatf("query%0d_cycle", i), qry_cyc_q[qb+i], c0 + 9 + int'(exp_q[i]));
      chk($sformatf("query%0d_tag", i), qry_tag_q[qb+i], tag);
      if (i > 0) chk($sformatf("query%0d_gap", i), (qry_cyc_q[qb+i] - qry_cyc_q[qb+i-1] - 1) >= GAP, 1);
    end
    chk("query_oe_clean", oe_bad, 0);
    chk("cmd_data_clean", stray, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] tag;
    int         d0, d1, d2;
    logic [7:0] v0, v1, v2;
    int         kind;
    logic [1:0] st;
    int         np;
  } vec_t;

  vec_t tbl[7];
  logic [255:0] spec_cdb;

  initial begin
    int ok, np;
    logic [1:0] st;
    logic [255:0] rc;
    tbl[0] = '{8'h00,  1, -1, -1, 8'h0C, 8'h00, 8'h00, 1, 2'b11, 1};
    tbl[1] = '{8'h5A,  1,  2,  1, 8'h00, 8'h04, 8'h0C, 1, 2'b11, 3};
    tbl[2] = '{8'hA5,  1, -1, -1, 8'h08, 8'h00, 8'h00, 1, 2'b10, 1};
    tbl[3] = '{8'h3C, -1, -1, -1, 8'h00, 8'h00, 8'h00, 2, 2'b00, 3};
    tbl[4] = '{8'h11,  0,  3, -1, 8'h04, 8'h0B, 8'h00, 1, 2'b10, 2};
    tbl[5] = '{8'hFF,  2,  0,  3, 8'h01, 8'h03, 8'h02, 2, 2'b00, 3};
    tbl[6] = '{8'h77, -1,  0, -1, 8'h00, 8'h0E, 8'h00, 1, 2'b11, 2};
    spec_cdb = '0;
    spec_cdb[31:0]   = 32'h00000040;
    spec_cdb[127:96] = 32'h01000008;
    for (int i = 0; i < MAXP; i++) begin plan_d[i] = -1; plan_v[i] = 8'h00; end

    // reset state
    repeat (3) @(negedge clock_host);
    chk("reset_flags", {req_ready, busy, cmdq_select, queryin_select, querydata_oe, done, timeout_err}, 7'b1000000);
    chk("reset_data", {cmdq_data, querydata_out, done_status}, 0);
    reset = 1'b0;

    // responses in idle are ignored
    @(negedge clock_host);
    force_rsp = 1'b1; force_val = 8'h0C;
    repeat (3) @(negedge clock_host);
    force_rsp = 1'b0;
    @(negedge clock_host);
    chk("idle_rsp_no_done", done_cnt, 0);
    chk("idle_rsp_ready", {req_ready, busy}, 2'b10);

    // table
    for (int t = 0; t < 7; t++) begin
      plan_d[0] = tbl[t].d0; plan_d[1] = tbl[t].d1; plan_d[2] = tbl[t].d2;
      plan_v[0] = tbl[t].v0; plan_v[1] = tbl[t].v1; plan_v[2] = tbl[t].v2;
      run_txn(spec_cdb, tbl[t].tag, t[0], ok, st, np);
      chk($sformatf("tbl%0d_kind", t), ok, tbl[t].kind);
      chk($sformatf("tbl%0d_status", t), st, tbl[t].st);
      chk($sformatf("tbl%0d_polls", t), np, tbl[t].np);
    end

    // randomized
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < ROWS; k++) rc[32*k +: 32] = $urandom();
      for (int i = 0; i < MAXP; i++) begin
        plan_d[i] = $urandom_range(0, TMO);
        if (plan_d[i] == TMO) plan_d[i] = -1;
        plan_v[i] = 8'($urandom_range(0, 255));
      end
      run_txn(rc, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ok, st, np);
    end

    // reset asserted while row 4 is on the command port
    @(negedge clock_host);
    req_valid = 1'b1; req_cdb = ~spec_cdb; req_tag = 8'h42; ok = cyc;
    @(negedge clock_host);
    req_valid = 1'b0;
    while (cyc < ok + 5) @(negedge clock_host);
    np = done_cnt + terr_cnt;
    chk("row4_before_reset", {cmdq_select, cmdq_data}, {1'b1, ~spec_cdb[159:128]});
    #2 reset = 1'b1;
    #1;
    chk("reset_async_drop", {cmdq_select, cmdq_data, req_ready, busy}, {1'b0, 32'h0, 1'b1, 1'b0});
    @(negedge clock_host);
    reset = 1'b0;
    repeat (4) @(negedge clock_host);
    chk("reset_no_pulse", done_cnt + terr_cnt - np, 0);
    plan_d[0] = 1; plan_v[0] = 8'h0C; plan_d[1] = -1; plan_d[2] = -1;
    run_txn(spec_cdb, 8'h42, 1'b0, ok, st, np);
    chk("restart_status", st, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hcmd_issuer.md
Name: hcmd_issuer

Overview:
Host-side command initiator for the IFQueue command/query interface. Takes one 256-bit CDB from host logic and serialises it as eight 32-bit rows on the command-queue port. It then polls command status over the query port until completion, error or timeout. It drives the ifq command and query ports exactly as the host bench does. The querydata tristate is resolved outside this block.

Parameters:
CDB_ROWS, 8, number of 32-bit rows per CDB; fixed at 8 for 256-bit CDB
POLL_GAP, 4, idle cycles between a failed poll and the next query (min 1)
RSP_TIMEOUT, 16, cycles to wait for queryout_select after a query before counting the poll as failed
MAX_POLLS, 255, failed polls before timeout is declared (8-bit counter)

Ports:
clock_host  in  1  host clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  command request valid
req_cdb  in  256  CDB; row k = req_cdb[32k+31:32k]
req_tag  in  8  query byte sent with each status query
req_ready  out  1  high iff FSM in IDLE
cmdq_select  out  1  command row strobe to ifq
cmdq_data  out  32  command row to ifq cmd_in
queryin_select  out  1  query strobe to ifq
querydata_out  out  8  query byte driven on querydata_inout
querydata_oe  out  1  tristate enable for querydata_out
queryout_select  in  1  ifq response strobe
querydata_in  in  8  sampled querydata_inout
done  out  1  one-cycle pulse: command finished
done_status  out  2  querydata_in[3:2] captured at finish; held until next accept
timeout_err  out  1  one-cycle pulse: MAX_POLLS exhausted
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0 except req_ready=1; row/poll/wait counters 0; latched CDB/tag cleared.
- All outputs registered except req_ready and busy, which decode the state register.
- States:
  - IDLE: on req_valid && req_ready at edge N, latch req_cdb and req_tag, clear done_status, go to ISSUE.
    - req_valid while not IDLE is ignored (not queued).
  - ISSUE: cmdq_select=1 on cycles N+1..N+8, contiguous and never broken. cmdq_data = row 0..7 in order.
    - After row 7, drop cmdq_select and zero cmdq_data in the same edge, go to QUERY.
  - QUERY: exactly one cycle (N+9 on first poll) with queryin_select=1, querydata_oe=1, querydata_out=latched tag. Then go to WAIT_RSP.
  - WAIT_RSP: queryin_select=0, querydata_oe=0. Wait counter increments per cycle.
    - On queryout_select=1, sample querydata_in[3:2]:
      - 2'b11 (complete) or 2'b10 (error): capture into done_status, go to DONE.
      - 2'b00/2'b01 (pending): failed poll.
    - Wait counter reaching RSP_TIMEOUT with no response: failed poll.
  - Failed poll: poll counter +1. If it now equals MAX_POLLS, go to TERR. Otherwise go to GAP.
  - GAP: POLL_GAP cycles with all query outputs low, then QUERY. Wait counter resets on entry to QUERY.
  - DONE: done=1 for one cycle, then IDLE.
  - TERR: timeout_err=1 for one cycle, done_status=2'b00, then IDLE.
- queryout_select seen in the QUERY cycle itself is also sampled. It is ignored in IDLE, ISSUE, GAP, DONE and TERR.
- querydata_oe and an incoming queryout_select may coincide in QUERY. Sampling still uses querydata_in; resolving contention is the wrapper's job.
- Poll counter is 8-bit and saturating. It is cleared only on accept or reset, never wraps.
- Reset asserted mid-operation: immediate return to IDLE, strobes drop asynchronously, no done or timeout_err pulse.

Test Plan:
- Reset then idle: req_ready=1, busy=0, every strobe 0; asserting queryout_select=1 with querydata_in=8'h0C produces no done.
- Write CDB (row0=32'h00000040, row3=32'h01000008, others 0), tag 8'h00, accepted at cycle N:
  - cmdq_select high N+1..N+8 with rows in order.
  - queryin_select at N+9.
  - Respond querydata_in=8'h0C at N+10 -> done pulse at N+11, done_status=2'b11, req_ready at N+12.
- Pending twice (8'h00, 8'h04), then 8'h0C:
  - exactly 3 query strobes, each gap ≥ POLL_GAP idle cycles;
  - done_status=2'b11.
- Error response 8'h08 on first poll -> done with done_status=2'b10, no timeout_err.
- No response ever, with MAX_POLLS=3 and RSP_TIMEOUT=4 -> 3 queries, then timeout_err pulse, done never asserts, back in IDLE.
- Reset at row 4 of ISSUE -> cmdq_select drops immediately, no pulse. A new request afterwards restarts from row 0.
